// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  // True for the ops that run the iterative datapath.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied combinationally to the result.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_c,
  output logic [WIDTH-1:0] o_lo_c,
  output logic             o_div0_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_dividend;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ge;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand magnitudes at load time.
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;

  // Multiply step: conditional add of |A| into the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc_hi[WIDTH-1:0]} + (r_acc_lo[0] ? {1'b0, r_opa} : '0);

  // Divide step: shift next dividend bit into the partial remainder, trial subtract.
  assign w_div_sh   = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opb});
  assign w_div_diff = w_div_sh - {1'b0, r_opb};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_dividend <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else if (i_load) begin
      r_acc_hi   <= '0;
      r_acc_lo   <= i_op[1] ? w_a_mag : w_b_mag;
      r_opa      <= w_a_mag;
      r_opb      <= w_b_mag;
      r_dividend <= i_a;
      r_is_div   <= i_op[1];
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
    end else if (i_step) begin
      if (r_is_div) begin
        r_acc_hi <= w_div_ge ? w_div_diff : w_div_sh;
        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
      end else begin
        r_acc_hi <= {1'b0, w_mul_sum[WIDTH:1]};
        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Sign correction of the finished magnitudes.
  assign w_prod     = {r_acc_hi[WIDTH-1:0], r_acc_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~r_acc_lo + WIDTH'(1)) : r_acc_lo;
  assign w_rem_fix  = r_neg_r ? (~r_acc_hi[WIDTH-1:0] + WIDTH'(1)) : r_acc_hi[WIDTH-1:0];
  assign o_div0_c   = r_is_div & (r_opb == '0);

  always_comb begin
    o_hi_c = w_prod_fix[PW-1:WIDTH];
    o_lo_c = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (o_div0_c) begin
        o_hi_c = r_dividend;
        o_lo_c = '1;
      end else begin
        o_hi_c = w_rem_fix;
        o_lo_c = w_quo_fix;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, HI/LO registers,
// pipeline stall and divide-by-zero pulse.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             div0
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_e    r_state;
  muldiv_state_e    w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_div0;

  logic             w_load;
  logic             w_step;
  logic             w_wr_res;
  logic             w_wr_hi;
  logic             w_wr_lo;
  logic             w_div0_nxt;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;
  logic             w_core_div0;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_op     (op),
    .i_a      (rs_val),
    .i_b      (rt_val),
    .o_hi_c   (w_core_hi),
    .o_lo_c   (w_core_lo),
    .o_div0_c (w_core_div0)
  );

  // Next-state and control decode; flush wins over every state action.
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_wr_res     = 1'b0;
    w_wr_hi      = 1'b0;
    w_wr_lo      = 1'b0;
    w_div0_nxt   = 1'b0;
    if (flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (is_iter_op(op)) begin
              w_load       = 1'b1;
              w_cnt_nxt    = CNT_W'(WIDTH - 1);
              w_next_state = ST_CALC;
            end else if (op == OP_MTHI) begin
              w_wr_hi = 1'b1;
            end else if (op == OP_MTLO) begin
              w_wr_lo = 1'b1;
            end
          end
        end
        ST_CALC: begin
          w_step = 1'b1;
          if (r_cnt == '0) begin
            w_next_state = ST_FIX;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          w_wr_res     = 1'b1;
          w_div0_nxt   = w_core_div0;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_next_state != ST_IDLE);
      r_div0  <= w_div0_nxt;
      if (w_wr_res) begin
        r_hi <= w_core_hi;
        r_lo <= w_core_lo;
      end
      if (w_wr_hi) r_hi <= rs_val;
      if (w_wr_lo) r_lo <= rs_val;
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = r_busy;
  assign div0  = r_div0;
  assign stall = r_busy & (start | rd_hilo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed results.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hilo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        div0;

  int n_checks;
  int n_errors;
  int cyc;

  muldiv_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .rd_hilo (rd_hilo),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall),
    .div0    (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from idle and wait (bounded) for busy to drop.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
    rd_hilo = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_div0", {31'b0, div0}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1;
    tick();

    run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, cyc);
    chk("mult_cycles", 32'(cyc), 32'd33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, cyc);
    chk("multu_cycles", 32'(cyc), 32'd33);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, cyc);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0000_0000);

    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);

    run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, cyc);
    chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", hi, 32'h0000_0001);

    run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0010, cyc);
    chk("divu_big_lo", lo, 32'h0FFF_FFFF);
    chk("divu_big_hi", hi, 32'h0000_000F);

    run_op(3'b011, 32'h0000_0007, 32'h0000_0000, cyc);
    chk("divu0_cycles", 32'(cyc), 32'd33);
    chk("divu0_hi", hi, 32'h0000_0007);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_pulse", {31'b0, div0}, 32'h1);
    tick();
    chk("divu0_pulse_end", {31'b0, div0}, 32'h0);

    run_op(3'b010, 32'hFFFF_FFFB, 32'h0000_0000, cyc);
    chk("div0_neg_hi", hi, 32'hFFFF_FFFB);
    chk("div0_neg_lo", lo, 32'hFFFF_FFFF);
    chk("div0_neg_pulse", {31'b0, div0}, 32'h1);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
    chk("div_ovf_nodiv0", {31'b0, div0}, 32'h0);

    // MTHI/MTLO and ignored encodings
    op = 3'b100; rs_val = 32'h0000_1234; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    op = 3'b101; rs_val = 32'h0000_5555; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_5555);
    chk("mtlo_hi_kept", hi, 32'h0000_1234);
    op = 3'b110; rs_val = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    op = 3'b111;
    tick();
    start = 1'b0;
    chk("noop_busy", {31'b0, busy}, 32'h0);
    chk("noop_hi", hi, 32'h0000_1234);
    chk("noop_lo", lo, 32'h0000_5555);

    // Back-to-back with a held second start and rd_hilo during the first op
    op = 3'b001; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
    tick();
    op = 3'b011; rs_val = 32'd100; rt_val = 32'd7; rd_hilo = 1'b1;
    #1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      chk("stall_busy", {31'b0, stall}, 32'h1);
      cyc++;
      tick();
    end
    chk("b2b_first_cycles", 32'(cyc), 32'd33);
    chk("b2b_stall_release", {31'b0, stall}, 32'h0);
    chk("b2b_first_hi", hi, 32'd0);
    chk("b2b_first_lo", lo, 32'd15);
    rd_hilo = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("b2b_second_cycles", 32'(cyc), 32'd33);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_second_lo", lo, 32'd14);

    // Flush during CALC
    op = 3'b100; rs_val = 32'h0000_AAAA; start = 1'b1;
    tick();
    op = 3'b101; rs_val = 32'h0000_5555;
    tick();
    op = 3'b011; rs_val = 32'd9; rt_val = 32'd0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("flush_calc_busy_before", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_calc_busy", {31'b0, busy}, 32'h0);
    chk("flush_calc_hi", hi, 32'h0000_AAAA);
    chk("flush_calc_lo", lo, 32'h0000_5555);
    chk("flush_calc_div0", {31'b0, div0}, 32'h0);
    tick();
    chk("flush_calc_div0_late", {31'b0, div0}, 32'h0);

    // Flush exactly in the FIX cycle
    op = 3'b011; rs_val = 32'd9; rt_val = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("flush_fix_busy_before", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_fix_busy", {31'b0, busy}, 32'h0);
    chk("flush_fix_hi", hi, 32'h0000_AAAA);
    chk("flush_fix_lo", lo, 32'h0000_5555);
    chk("flush_fix_div0", {31'b0, div0}, 32'h0);

    // Flush in IDLE drops a concurrent MTHI
    op = 3'b100; rs_val = 32'hDEAD_0000; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_hi", hi, 32'h0000_AAAA);
    chk("flush_idle_busy", {31'b0, busy}, 32'h0);

    // Reset mid-divide
    op = 3'b010; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("midrst_busy_after", {31'b0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
